// File: rtl/spinn_aer_out_mapper.sv
// SpiNNaker multicast packet -> AER word mapper with parity check, key filter and output FIFO.
// Define OUT_MAPPER_PAYLOAD_EN to forward the payload word after the key for packets that carry one.
module spinn_aer_out_mapper #(
  parameter int unsigned AER_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     cfg_key_mask,
  input  logic [31:0]                     cfg_key_match,
  input  logic                            cnt_clr,
  input  logic [71:0]                     opkt_data,
  input  logic                            opkt_vld,
  output logic                            opkt_rdy,
  output logic [AER_WIDTH-1:0]            oaer_data,
  output logic                            oaer_vld,
  input  logic                            oaer_rdy,
  output logic                            parity_err,
  output logic [CNT_WIDTH-1:0]            perr_cnt,
  output logic [CNT_WIDTH-1:0]            drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
`ifdef OUT_MAPPER_PAYLOAD_EN
  localparam int unsigned NEED = 2;
`else
  localparam int unsigned NEED = 1;
`endif
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] NEED_L  = LW'(NEED);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 parity_err_q, parity_err_d;
  logic [CNT_WIDTH-1:0] perr_cnt_q, perr_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [AER_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [31:0]   key;
  logic [1:0]    pkt_type;
  logic          pl_flag, parity_ok, accept, filter_hit, fwd, push_two, pop;
  logic          perr_inc, drop_inc;
  logic [LW-1:0] push_n;

  always_comb begin
    key        = opkt_data[39:8];
    pkt_type   = opkt_data[7:6];
    pl_flag    = opkt_data[1];
    parity_ok  = pl_flag ? (^opkt_data) : (^opkt_data[39:0]);
    opkt_rdy   = (DEPTH_L - level_q) >= NEED_L;
    accept     = opkt_vld & opkt_rdy;
    filter_hit = (key & cfg_key_mask) == cfg_key_match;
    fwd        = accept & parity_ok & (pkt_type == 2'b00) & filter_hit;
`ifdef OUT_MAPPER_PAYLOAD_EN
    push_two   = fwd & pl_flag;
`else
    push_two   = 1'b0;
`endif
    push_n     = fwd ? (push_two ? LW'(2) : LW'(1)) : '0;
    pop        = (level_q != '0) & oaer_rdy;
    perr_inc   = accept & ~parity_ok;
    drop_inc   = accept & parity_ok & ~fwd;
  end

  always_comb begin
    level_d      = level_q + push_n - LW'(pop);
    wr_ptr_d     = wr_ptr_q + PW'(push_n);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    parity_err_d = perr_inc;

    // Clear wins over increment; increments stop at all-ones.
    perr_cnt_d = perr_cnt_q;
    if (cnt_clr)                              perr_cnt_d = '0;
    else if (perr_inc && (perr_cnt_q != '1))  perr_cnt_d = perr_cnt_q + 1'b1;

    drop_cnt_d = drop_cnt_q;
    if (cnt_clr)                              drop_cnt_d = '0;
    else if (drop_inc && (drop_cnt_q != '1))  drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      parity_err_q <= 1'b0;
      perr_cnt_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      parity_err_q <= parity_err_d;
      perr_cnt_q   <= perr_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Storage is unreset; level_q gates visibility so stale entries are never presented.
  always_ff @(posedge clk) begin
    if (fwd) mem_q[wr_ptr_q] <= key[AER_WIDTH-1:0];
`ifdef OUT_MAPPER_PAYLOAD_EN
    if (push_two) mem_q[wr_ptr_q + PW'(1)] <= opkt_data[40 +: AER_WIDTH];
`endif
  end

  assign oaer_data  = mem_q[rd_ptr_q];
  assign oaer_vld   = level_q != '0;
  assign parity_err = parity_err_q;
  assign perr_cnt   = perr_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_spinn_aer_out_mapper.sv
// Directed self-checking bench for spinn_aer_out_mapper (16-bit AER words, 4-entry FIFO).
module tb_spinn_aer_out_mapper;

  localparam int AW = 16;
`ifdef OUT_MAPPER_PAYLOAD_EN
  localparam int EXP_FULL = 3;
`else
  localparam int EXP_FULL = 4;
`endif

  logic          clk = 1'b0;
  logic          rst, cnt_clr, opkt_vld, opkt_rdy, oaer_vld, oaer_rdy, parity_err;
  logic [31:0]   cfg_key_mask, cfg_key_match;
  logic [71:0]   opkt_data;
  logic [AW-1:0] oaer_data;
  logic [15:0]   perr_cnt, drop_cnt;
  logic [2:0]    fifo_level;

  int checks = 0;
  int errors = 0;

  spinn_aer_out_mapper #(.AER_WIDTH(AW), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cfg_key_mask(cfg_key_mask), .cfg_key_match(cfg_key_match),
    .cnt_clr(cnt_clr), .opkt_data(opkt_data), .opkt_vld(opkt_vld), .opkt_rdy(opkt_rdy),
    .oaer_data(oaer_data), .oaer_vld(oaer_vld), .oaer_rdy(oaer_rdy), .parity_err(parity_err),
    .perr_cnt(perr_cnt), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [71:0] mk(input logic [1:0] t, input logic [31:0] key,
                                     input logic [31:0] pl, input logic flag, input logic good);
    logic [71:0] p;
    logic        x;
    p    = {pl, key, t, 4'b0000, flag, 1'b0};
    x    = flag ? (^p) : (^p[39:0]);
    p[0] = good ? ~x : x;
    return p;
  endfunction

  // Inputs change only on negedges; opkt_rdy must already be 1.
  task automatic send(input logic [71:0] p);
    opkt_data = p;
    opkt_vld  = 1'b1;
    @(negedge clk);
    opkt_vld  = 1'b0;
  endtask

  task automatic pop_one();
    oaer_rdy = 1'b1;
    @(negedge clk);
    oaer_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cnt_clr = 1'b0; opkt_vld = 1'b0; oaer_rdy = 1'b0; opkt_data = '0;
    cfg_key_mask = '0; cfg_key_match = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (oaer_vld !== 1'b0)   begin errors++; $display("FAIL reset_vld got %b exp 0", oaer_vld); end
    checks++; if (opkt_rdy !== 1'b1)   begin errors++; $display("FAIL reset_rdy got %b exp 1", opkt_rdy); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", parity_err); end
    checks++; if (perr_cnt !== 16'd0 || drop_cnt !== 16'd0)
      begin errors++; $display("FAIL reset_cnts got %h/%h exp 0/0", perr_cnt, drop_cnt); end
  endtask

  task automatic test_forward();
    send(mk(2'b00, 32'h0000_1234, '0, 1'b0, 1'b1));
    checks++; if (oaer_vld !== 1'b1)     begin errors++; $display("FAIL fwd_vld got %b exp 1", oaer_vld); end
    checks++; if (oaer_data !== 16'h1234) begin errors++; $display("FAIL fwd_data got %h exp 1234", oaer_data); end
    checks++; if (perr_cnt !== 16'd0 || drop_cnt !== 16'd0)
      begin errors++; $display("FAIL fwd_cnts got %h/%h exp 0/0", perr_cnt, drop_cnt); end
    pop_one();
    checks++; if (oaer_vld !== 1'b0) begin errors++; $display("FAIL fwd_pop_vld got %b exp 0", oaer_vld); end
  endtask

  task automatic test_parity();
    send(mk(2'b00, 32'h0000_0055, '0, 1'b0, 1'b0));
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL perr_pulse got %b exp 1", parity_err); end
    checks++; if (perr_cnt !== 16'd1)  begin errors++; $display("FAIL perr_cnt got %0d exp 1", perr_cnt); end
    checks++; if (oaer_vld !== 1'b0)   begin errors++; $display("FAIL perr_vld got %b exp 0", oaer_vld); end
    checks++; if (opkt_rdy !== 1'b1)   begin errors++; $display("FAIL perr_rdy got %b exp 1", opkt_rdy); end
    @(negedge clk);
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL perr_pulse_end got %b exp 0", parity_err); end
    checks++; if (drop_cnt !== 16'd0)  begin errors++; $display("FAIL perr_drop got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_filter();
    cfg_key_mask = 32'hFFFF_0000; cfg_key_match = 32'h0001_0000;
    send(mk(2'b00, 32'h0001_00AA, '0, 1'b0, 1'b1));
    send(mk(2'b00, 32'h0002_00BB, '0, 1'b0, 1'b1));
    send(mk(2'b01, 32'h0001_00CC, '0, 1'b0, 1'b1));
    checks++; if (fifo_level !== 3'd1)   begin errors++; $display("FAIL filt_level got %0d exp 1", fifo_level); end
    checks++; if (oaer_data !== 16'h00AA) begin errors++; $display("FAIL filt_data got %h exp 00aa", oaer_data); end
    checks++; if (drop_cnt !== 16'd2)    begin errors++; $display("FAIL filt_drop got %0d exp 2", drop_cnt); end
    pop_one();
    cfg_key_mask = '0; cfg_key_match = '0;
  endtask

  task automatic test_payload_flag();
    logic [71:0] p;
    send(mk(2'b00, 32'h0000_000A, 32'h0000_000B, 1'b1, 1'b1));
`ifdef OUT_MAPPER_PAYLOAD_EN
    checks++; if (fifo_level !== 3'd2)   begin errors++; $display("FAIL pl_level got %0d exp 2", fifo_level); end
    checks++; if (oaer_data !== 16'h000A) begin errors++; $display("FAIL pl_word0 got %h exp 000a", oaer_data); end
    pop_one();
    checks++; if (oaer_data !== 16'h000B) begin errors++; $display("FAIL pl_word1 got %h exp 000b", oaer_data); end
    pop_one();
`else
    checks++; if (fifo_level !== 3'd1)   begin errors++; $display("FAIL pl_level got %0d exp 1", fifo_level); end
    checks++; if (oaer_data !== 16'h000A) begin errors++; $display("FAIL pl_word0 got %h exp 000a", oaer_data); end
    pop_one();
`endif
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL pl_drain got %0d exp 0", fifo_level); end
    // Odd parity over [39:0] alone, but payload 0xB flips the full 72-bit parity.
    p = mk(2'b00, 32'h0000_000C, '0, 1'b1, 1'b1);
    p[71:40] = 32'h0000_000B;
    send(p);
    checks++; if (parity_err !== 1'b1 || fifo_level !== 3'd0)
      begin errors++; $display("FAIL pl_parity got perr=%b lvl=%0d exp 1/0", parity_err, fifo_level); end
    checks++; if (perr_cnt !== 16'd2) begin errors++; $display("FAIL pl_perr_cnt got %0d exp 2", perr_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] keys [6];
    logic [15:0] got [$];
    int          idx, lvl_before;
    logic        acc, swap_seen;
    for (int unsigned i = 0; i < 6; i++) keys[i] = 16'h1001 + 16'(i);
    idx = 0; swap_seen = 1'b0; oaer_rdy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      opkt_vld = (idx < 6);
      if (idx < 6) opkt_data = mk(2'b00, {16'h0, keys[idx]}, '0, 1'b0, 1'b1);
      acc = opkt_vld && opkt_rdy;
      @(negedge clk);
      if (acc) idx++;
    end
    opkt_vld = 1'b0;
    checks++; if (fifo_level !== 3'(EXP_FULL)) begin errors++; $display("FAIL b2b_full_level got %0d exp %0d", fifo_level, EXP_FULL); end
    checks++; if (opkt_rdy !== 1'b0) begin errors++; $display("FAIL b2b_full_rdy got %b exp 0", opkt_rdy); end
    oaer_rdy = 1'b1;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      opkt_vld = (idx < 6);
      if (idx < 6) opkt_data = mk(2'b00, {16'h0, keys[idx]}, '0, 1'b0, 1'b1);
      acc = opkt_vld && opkt_rdy;
      if (oaer_vld) got.push_back(oaer_data);
      lvl_before = int'(fifo_level);
      @(negedge clk);
      if (acc) idx++;
      if (acc && !swap_seen) begin
        swap_seen = 1'b1;
        checks++; if (int'(fifo_level) !== lvl_before)
          begin errors++; $display("FAIL b2b_swap_level got %0d exp %0d", fifo_level, lvl_before); end
      end
    end
    opkt_vld = 1'b0; oaer_rdy = 1'b0;
    checks++; if (!swap_seen) begin errors++; $display("FAIL b2b_swap_seen got 0 exp 1"); end
    checks++; if (got.size() !== 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", got.size()); end
    for (int unsigned i = 0; i < 6 && i < got.size(); i++) begin
      checks++; if (got[i] !== keys[i]) begin errors++; $display("FAIL b2b_word%0d got %h exp %h", i, got[i], keys[i]); end
    end
    @(negedge clk);
    checks++; if (oaer_vld !== 1'b0 || fifo_level !== 3'd0)
      begin errors++; $display("FAIL b2b_drain got vld=%b lvl=%0d exp 0/0", oaer_vld, fifo_level); end
  endtask

  task automatic test_saturation();
    opkt_data = mk(2'b01, 32'h0000_0001, '0, 1'b0, 1'b1);
    opkt_vld  = 1'b1;
    repeat (65540) @(negedge clk);
    opkt_vld  = 1'b0;
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_drop got %h exp ffff", drop_cnt); end
    @(negedge clk);
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", drop_cnt); end
    cnt_clr = 1'b1;
    send(opkt_data);
    cnt_clr = 1'b0;
    checks++; if (drop_cnt !== 16'd0 || perr_cnt !== 16'd0)
      begin errors++; $display("FAIL clr_prio got %h/%h exp 0/0", drop_cnt, perr_cnt); end
    send(opkt_data);
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL clr_resume got %0d exp 1", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    oaer_rdy = 1'b0;
    send(mk(2'b00, 32'h0000_0011, '0, 1'b0, 1'b1));
    send(mk(2'b00, 32'h0000_0022, '0, 1'b0, 1'b1));
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL rmid_pre got %0d exp 2", fifo_level); end
    #2 rst = 1'b1;
    #1;
    checks++; if (fifo_level !== 3'd0 || oaer_vld !== 1'b0)
      begin errors++; $display("FAIL rmid_async got lvl=%0d vld=%b exp 0/0", fifo_level, oaer_vld); end
    @(negedge clk);
    rst = 1'b0;
    oaer_rdy = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (oaer_vld !== 1'b0 || drop_cnt !== 16'd0)
      begin errors++; $display("FAIL rmid_idle got vld=%b drop=%0d exp 0/0", oaer_vld, drop_cnt); end
    oaer_rdy = 1'b0;
    send(mk(2'b00, 32'h0000_0077, '0, 1'b0, 1'b1));
    checks++; if (oaer_vld !== 1'b1 || oaer_data !== 16'h0077 || fifo_level !== 3'd1)
      begin errors++; $display("FAIL rmid_new got vld=%b data=%h lvl=%0d exp 1/0077/1", oaer_vld, oaer_data, fifo_level); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_parity();
    test_filter();
    test_payload_flag();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
